// File: rtl/serial_add_ctrl.sv
// Multi-word add/subtract controller sequencing a shared external 32-bit adder,
// one word per cycle from least significant upward, with carry chained between words.
//
// state  | meaning
// S_IDLE | waiting for start, adder inputs driven to zero
// S_RUN  | one operand word per cycle through the external adder
// S_DONE | single-cycle completion, result and cout valid
module serial_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  cin,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout
);

  localparam int IW = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state, state_next;
  logic [IW-1:0]       idx;
  logic                carry;
  logic [32*WORDS-1:0] a_q, b_q;
  logic                last, accept;

  assign last   = (idx == IW'(WORDS - 1));
  assign accept = start && (state != S_RUN);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last) state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_cin = carry;
      for (int i = 0; i < WORDS; i++) begin
        if (idx == IW'(i)) begin
          add_a = a_q[i*32 +: 32];
          add_b = b_q[i*32 +: 32];
        end
      end
    end
  end

  // Subtract is A + ~B + 1; the inversion is applied once at latch time,
  // so the run phase is identical for both operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q   <= op_a;
        b_q   <= sub ? ~op_b : op_b;
        idx   <= '0;
        carry <= sub ? 1'b1 : cin;
      end else if (state == S_RUN) begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx == IW'(i)) result[i*32 +: 32] <= add_sum;
        end
        carry <= add_cout;
        idx   <= idx + 1'b1;
        if (last) cout <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WORDS=4) with a behavioural 32-bit adder
// closing the loop on the add_* ports.
module tb_serial_add_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic          clk = 1'b0;
  logic          rst, start, sub, cin;
  logic [W-1:0]  op_a, op_b;
  logic [31:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          busy, done, cout;
  logic [W-1:0]  result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  serial_add_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .result(result), .cout(cout)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the accepting edge; returns in the DONE cycle.
  task automatic wait_done(input bit inject, output int done_c, output int busy_n);
    int  c;
    bit  seen;
    c = 1; seen = 0; done_c = 0; busy_n = 0;
    while (c <= 20 && !seen) begin
      if (busy) busy_n++;
      if (done) begin
        done_c = c;
        seen   = 1;
      end else begin
        if (inject && c == 2) begin
          op_a  = {4{32'h1234_5678}};
          op_b  = {4{32'h0F0F_0F0F}};
          sub   = 1'b1;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        step();
        c++;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb, input bit inject,
                       input logic [W-1:0] exp_res, input logic exp_cout);
    int done_c, busy_n;
    logic [31:0] b0;
    op_a = a; op_b = b; cin = ci; sub = sb; start = 1'b1;
    step();
    start = 1'b0;
    b0 = sb ? ~b[31:0] : b[31:0];
    chk({tag, " add_a0"}, W'(add_a), W'(a[31:0]));
    chk({tag, " add_b0"}, W'(add_b), W'(b0));
    chk({tag, " add_cin0"}, W'(add_cin), W'(sb ? 1'b1 : ci));
    wait_done(inject, done_c, busy_n);
    chk({tag, " done_cycle"}, W'(done_c), W'(5));
    chk({tag, " busy_cycles"}, W'(busy_n), W'(4));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " cout"}, W'(cout), W'(exp_cout));
  endtask

  initial begin
    int done_c, busy_n;
    bit any_done;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    step();
    // reset wins over a simultaneous start
    start = 1'b1; op_a = 128'd7; op_b = 128'd9;
    step();
    start = 1'b0;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_add_a", W'(add_a), '0);
    chk("rst_add_b", W'(add_b), '0);
    chk("rst_add_cin", W'(add_cin), '0);
    rst = 1'b0;
    step();

    do_op("wrap", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 0, 128'd0, 1'b1);
    step();
    chk("wrap_done_low", W'(done), W'(0));
    chk("wrap_idle_busy", W'(busy), W'(0));
    chk("wrap_idle_add_a", W'(add_a), '0);
    chk("wrap_hold", result, 128'd0);

    do_op("cin_carry", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd0, 1'b1, 1'b0, 0,
          128'h00000001_00000000_00000000_00000000, 1'b0);
    step();
    do_op("sub_borrow", 128'd0, 128'd1, 1'b0, 1'b1, 0, {128{1'b1}}, 1'b0);
    step();
    do_op("sub_small", 128'd5, 128'd3, 1'b1, 1'b1, 0, 128'd2, 1'b1);
    step();
    do_op("busy_start", 128'd10, 128'd20, 1'b0, 1'b0, 1, 128'd30, 1'b0);
    start = 1'b0;
    step();
    chk("busy_start_no_rerun", W'(busy), W'(0));

    // reset in the middle of a run, at idx=2
    op_a = {128{1'b1}}; op_b = 128'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midrst_add_a2", W'(add_a), W'(32'hFFFF_FFFF));
    rst = 1'b1;
    step();
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_result", result, '0);
    chk("midrst_cout", W'(cout), W'(0));
    chk("midrst_done", W'(done), W'(0));
    rst = 1'b0;
    any_done = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) any_done = 1;
    end
    chk("midrst_no_done", W'(any_done), W'(0));
    do_op("after_rst", 128'd5, 128'd7, 1'b0, 1'b0, 0, 128'd12, 1'b0);

    // back-to-back: start held during DONE
    op_a = 128'd100; op_b = 128'd50; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy", W'(busy), W'(1));
    chk("b2b_done_low", W'(done), W'(0));
    wait_done(0, done_c, busy_n);
    chk("b2b_done_cycle", W'(done_c), W'(5));
    chk("b2b_result", result, 128'd150);
    chk("b2b_cout", W'(cout), W'(0));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 32-bit words per operand (legal 2..16).
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to begin an operation, sampled only when accepted (REQ-014).
REQ-005 SHALL have port sub, input, 1: 0 selects A+B+cin; 1 selects A-B.
REQ-006 SHALL have ports op_a and op_b, input, 32*WORDS each, the operands; word i occupies bits [32i+31:32i].
REQ-007 SHALL have port cin, input, 1, the carry-in for add; ignored when sub=1.
REQ-008 SHALL have ports add_a, add_b (output, 32 each) and add_cin (output, 1), which drive the shared external 32-bit adder.
REQ-009 SHALL have ports add_sum (input, 32) and add_cout (input, 1), the combinational result of the external adder.
REQ-010 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have ports result (output, 32*WORDS) and cout (output, 1): the final sum and carry-out (carry=1 on subtract means no borrow).

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE, plus a word index idx of width clog2(WORDS)+1 and a carry register.
REQ-014 On start=1 in IDLE or DONE, the block SHALL latch op_a, op_b (bitwise inverted if sub=1) and sub, set idx=0, set carry=(sub ? 1 : cin), and go to RUN.
REQ-015 start asserted in RUN SHALL be ignored; latched operands and sub SHALL remain unchanged.
REQ-016 In RUN, add_a, add_b and add_cin SHALL equal latched A word idx, latched B word idx and the carry register.
REQ-017 In RUN, each cycle SHALL write add_sum into result word idx, load carry with add_cout and increment idx.
REQ-018 RUN SHALL last exactly WORDS cycles; after the cycle with idx=WORDS-1, the block SHALL go to DONE with cout equal to the final add_cout.
REQ-019 done SHALL be high only in the single DONE cycle; DONE SHALL then go to IDLE, or to RUN if start=1.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 Latency: start accepted at edge T SHALL give done=1 in the cycle following edge T+WORDS.
REQ-022 In IDLE and DONE, add_a, add_b and add_cin SHALL drive 0.
REQ-023 In RUN, result words not yet written SHALL keep their previous values; result and cout SHALL hold until the next operation writes them.
REQ-024 Carry SHALL propagate across all word boundaries, including a full-width wrap to 0.

Reset
REQ-025 rst=1 SHALL, at the next edge and from any state including mid-RUN, force state=IDLE, idx=0, carry=0, result=0, cout=0, busy=0 and done=0.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 After reset is released, the first start SHALL behave exactly as REQ-014.

Verification (WORDS=4; bench supplies a behavioural 32-bit adder on add_*)
REQ-028 SHALL cover: op_a=all-ones (128b), op_b=1, cin=0, sub=0 -> result=0, cout=1, done exactly 5 cycles after the start edge, busy high for 4 cycles.
REQ-029 SHALL cover: op_a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, op_b=0, cin=1 -> result=0x00000001_00000000_00000000_00000000, cout=0.
REQ-030 SHALL cover: sub=1, op_a=0, op_b=1 -> result=all-ones, cout=0; then sub=1, op_a=5, op_b=3 -> result=2, cout=1.
REQ-031 SHALL cover: a second start with different operands pulsed while busy -> ignored, and the first result is unchanged.
REQ-032 SHALL cover: rst asserted in RUN at idx=2 -> next cycle busy=0, result=0, cout=0, no done pulse; a subsequent start gives a correct result.
REQ-033 SHALL cover: start held high during the DONE cycle -> new operation begins with no IDLE cycle, busy high the cycle after done.
